video_timing_detect: RTL
========================

VIDEO_TIMING_DETECT -- requirements
Module: video_timing_detect

Interface
REQ-001 Parameter: LOCK_FRAMES, 2, consecutive matching frames required to enter LOCKED (range 1..15).
REQ-002 Parameter: TIMEOUT_CLKS, 4000000, clocks without a VS leading edge before returning to SEARCH.
REQ-003 Parameter: HS_ACTIVE_HIGH, 1, HS polarity (1 = active-high).
REQ-004 Parameter: VS_ACTIVE_HIGH, 1, VS polarity (1 = active-high).
REQ-005 Reset is asynchronous and active-high; one clock.
REQ-006 Port: clk  input  1  pixel clock; all logic on rising edge.
REQ-007 Port: reset  input  1  asynchronous, active-high reset.
REQ-008 Port: vid_de  input  1  incoming data enable.
REQ-009 Port: vid_hs  input  1  incoming horizontal sync.
REQ-010 Port: vid_vs  input  1  incoming vertical sync.
REQ-011 Port: pix_de  output  1  delayed DE, aligned with pix_x/pix_y.
REQ-012 Port: pix_x  output  12  active-pixel column, 0 = first DE pixel of a line.
REQ-013 Port: pix_y  output  12  active-line row, 0 = first line of a frame with DE.
REQ-014 Port: h_total, h_active, v_total, v_active  output  12 each  latched frame measurements.
REQ-015 Port: locked  output  1  high in LOCKED state.
REQ-016 Port: mode  output  4  detected format code.
REQ-017 Port: lock_lost  output  1  one-clock pulse on LOCKED exit.

Function
REQ-018 vid_de/hs/vs registered once; HS/VS normalised to active-high by polarity parameters; edges detected on the registered copies.
REQ-019 pix_de, pix_x, pix_y registered; latency 2 clocks from vid_de to pix_de.
REQ-020 pix_x: 0 on DE rising edge, +1 per DE-high clock; holds while DE low.
REQ-021 pix_y: cleared at VS leading edge; 0 on first DE line after it; +1 on each subsequent DE rising edge.
REQ-022 h_total_cnt: clocks between HS leading edges; h_active_cnt: DE-high clocks in the line; v_total_cnt: HS leading edges between VS leading edges; v_active_cnt: DE rising edges in the frame.
REQ-023 All internal counters 12-bit, saturate at 4095, never wrap.
REQ-024 Frame snapshot at each VS leading edge: last completed line's h_total/h_active plus frame v_total/v_active; outputs update only in MEASURE/LOCKED.
REQ-025 FSM states: SEARCH, MEASURE, LOCKED.
REQ-026 SEARCH -> MEASURE on first VS leading edge; counters cleared; match_cnt = 0.
REQ-027 MEASURE: at each VS edge, snapshot equals previous and all four nonzero -> match_cnt+1, else match_cnt = 0; match_cnt == LOCK_FRAMES -> LOCKED.
REQ-028 LOCKED: snapshot differs -> MEASURE, match_cnt = 0, lock_lost pulses one clock.
REQ-029 Any state: TIMEOUT_CLKS clocks without VS edge -> SEARCH; lock_lost pulses if leaving LOCKED.
REQ-030 mode valid only when locked, else 0: 1 = 640x480 (800x525), 2 = 1280x720 (1650x750), 3 = 1920x1080 (2200x1125), 15 = locked but unlisted.
REQ-031 Simultaneous VS and HS leading edges: HS counted into the ending frame before snapshot.

Reset
REQ-032 Reset forces SEARCH; all outputs, counters, snapshots, match_cnt, timeout counter to 0.
REQ-033 Reset mid-frame: measurement restarts; no output changes until a full frame after next VS edge.

Verification
REQ-034 20x10 timing (h_active 16, v_active 6), LOCK_FRAMES=2 -> locked rises at third VS edge after reset; h_total=20, h_active=16, v_total=10, v_active=6, mode=15.
REQ-035 Locked stream, one frame with h_active 15 -> locked falls, lock_lost pulses once, relock after 2 good frames.
REQ-036 1920x1080 (2200x1125) -> mode=3; pix_x reaches 1919, pix_y reaches 1079; pix_de 2 clocks after vid_de.
REQ-037 VS stopped, TIMEOUT_CLKS=100 -> SEARCH after 100 clocks, locked=0, mode=0.
REQ-038 HS_ACTIVE_HIGH=0, VS_ACTIVE_HIGH=0 with inverted syncs -> same results as REQ-034.
REQ-039 Reset asserted mid-line in LOCKED -> all outputs 0 immediately; relock per REQ-034.

Source files
------------

// File: rtl/video_timing_detect.sv
// Video timing detector: measures an incoming DE/HS/VS raster, locks onto a stable
// format, classifies it, and emits active-pixel coordinates aligned with a delayed DE.
module video_timing_detect #(
  parameter int LOCK_FRAMES    = 2,
  parameter int TIMEOUT_CLKS   = 4000000,
  parameter bit HS_ACTIVE_HIGH = 1'b1,
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_de,
  input  logic        vid_hs,
  input  logic        vid_vs,
  output logic        pix_de,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic        locked,
  output logic [3:0]  mode,
  output logic        lock_lost
);
  localparam int              TO_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]      LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  function automatic logic [11:0] f_sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [3:0] f_mode(input logic [11:0] ht, input logic [11:0] ha,
                                        input logic [11:0] vt, input logic [11:0] va);
    if (ht == 12'd800  && ha == 12'd640  && vt == 12'd525  && va == 12'd480)  return 4'd1;
    if (ht == 12'd1650 && ha == 12'd1280 && vt == 12'd750  && va == 12'd720)  return 4'd2;
    if (ht == 12'd2200 && ha == 12'd1920 && vt == 12'd1125 && va == 12'd1080) return 4'd3;
    return 4'd15;
  endfunction

  logic r_de, r_hs, r_vs, r_de_d, r_hs_d, r_vs_d;
  logic w_de_rise, w_hs_edge, w_vs_edge;

  // Input register stage; syncs normalised to active-high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_de   <= 1'b0;
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_de_d <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_de   <= vid_de;
      r_hs   <= vid_hs ~^ HS_ACTIVE_HIGH;
      r_vs   <= vid_vs ~^ VS_ACTIVE_HIGH;
      r_de_d <= r_de;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
    end
  end

  assign w_de_rise = r_de & ~r_de_d;
  assign w_hs_edge = r_hs & ~r_hs_d;
  assign w_vs_edge = r_vs & ~r_vs_d;

  logic r_first_line;

  // Pixel coordinate stage, aligned with pix_de
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_de       <= 1'b0;
      pix_x        <= 12'd0;
      pix_y        <= 12'd0;
      r_first_line <= 1'b1;
    end else begin
      pix_de <= r_de;
      if (w_de_rise)  pix_x <= 12'd0;
      else if (r_de)  pix_x <= f_sat_inc(pix_x);
      if (w_vs_edge) begin
        pix_y        <= 12'd0;
        r_first_line <= 1'b1;
      end else if (w_de_rise) begin
        pix_y        <= r_first_line ? 12'd0 : f_sat_inc(pix_y);
        r_first_line <= 1'b0;
      end
    end
  end

  logic [11:0] r_h_cnt, r_ha_cnt, r_line_ht, r_line_ha, r_v_cnt, r_va_cnt;

  // Raster counters; blank lines keep the last active line's width
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt   <= 12'd0;
      r_ha_cnt  <= 12'd0;
      r_line_ht <= 12'd0;
      r_line_ha <= 12'd0;
      r_v_cnt   <= 12'd0;
      r_va_cnt  <= 12'd0;
    end else begin
      if (w_hs_edge) begin
        r_h_cnt   <= 12'd1;
        r_line_ht <= r_h_cnt;
        if (r_ha_cnt != 12'd0) r_line_ha <= r_ha_cnt;
        r_ha_cnt  <= {11'd0, r_de};
      end else begin
        r_h_cnt <= f_sat_inc(r_h_cnt);
        if (r_de) r_ha_cnt <= f_sat_inc(r_ha_cnt);
      end
      if (w_vs_edge) begin
        r_v_cnt  <= 12'd0;
        r_va_cnt <= 12'd0;
      end else begin
        if (w_hs_edge) r_v_cnt  <= f_sat_inc(r_v_cnt);
        if (w_de_rise) r_va_cnt <= f_sat_inc(r_va_cnt);
      end
    end
  end

  // A coincident HS edge closes the ending frame before the snapshot is taken
  logic [11:0] w_snap_ht, w_snap_ha, w_snap_vt, w_snap_va;
  assign w_snap_ht = w_hs_edge ? r_h_cnt : r_line_ht;
  assign w_snap_ha = (w_hs_edge && r_ha_cnt != 12'd0) ? r_ha_cnt : r_line_ha;
  assign w_snap_vt = w_hs_edge ? f_sat_inc(r_v_cnt) : r_v_cnt;
  assign w_snap_va = r_va_cnt;

  state_t          r_state;
  logic [3:0]      r_match;
  logic [11:0]     r_prev_ht, r_prev_ha, r_prev_vt, r_prev_va;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_snap_ok, w_snap_eq, w_timeout;
  logic [3:0]      w_match_nxt;

  assign w_snap_ok = (w_snap_ht != 12'd0) && (w_snap_ha != 12'd0) &&
                     (w_snap_vt != 12'd0) && (w_snap_va != 12'd0);
  assign w_snap_eq = {w_snap_ht, w_snap_ha, w_snap_vt, w_snap_va} ==
                     {r_prev_ht, r_prev_ha, r_prev_vt, r_prev_va};
  assign w_timeout = ~w_vs_edge & (r_to_cnt == TO_LAST);
  // A valid frame that differs from its predecessor starts a new run of one
  assign w_match_nxt = (w_snap_ok && w_snap_eq) ? ((r_match == 4'd15) ? r_match : r_match + 4'd1) :
                       w_snap_ok ? 4'd1 : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_SEARCH;
      r_match   <= 4'd0;
      r_prev_ht <= 12'd0;
      r_prev_ha <= 12'd0;
      r_prev_vt <= 12'd0;
      r_prev_va <= 12'd0;
      r_to_cnt  <= '0;
      h_total   <= 12'd0;
      h_active  <= 12'd0;
      v_total   <= 12'd0;
      v_active  <= 12'd0;
      locked    <= 1'b0;
      mode      <= 4'd0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      r_to_cnt  <= (w_vs_edge || w_timeout) ? '0 : r_to_cnt + TO_W'(1);
      if (w_timeout) begin
        r_state   <= S_SEARCH;
        r_match   <= 4'd0;
        locked    <= 1'b0;
        mode      <= 4'd0;
        lock_lost <= (r_state == S_LOCKED);
      end else if (w_vs_edge) begin
        case (r_state)
          S_SEARCH: begin
            r_state   <= S_MEASURE;
            r_match   <= 4'd0;
            r_prev_ht <= 12'd0;
            r_prev_ha <= 12'd0;
            r_prev_vt <= 12'd0;
            r_prev_va <= 12'd0;
          end
          S_MEASURE: begin
            {h_total, h_active, v_total, v_active}     <= {w_snap_ht, w_snap_ha, w_snap_vt, w_snap_va};
            {r_prev_ht, r_prev_ha, r_prev_vt, r_prev_va} <= {w_snap_ht, w_snap_ha, w_snap_vt, w_snap_va};
            r_match <= w_match_nxt;
            if (w_match_nxt >= LOCK_N) begin
              r_state <= S_LOCKED;
              locked  <= 1'b1;
              mode    <= f_mode(w_snap_ht, w_snap_ha, w_snap_vt, w_snap_va);
            end
          end
          S_LOCKED: begin
            {h_total, h_active, v_total, v_active}     <= {w_snap_ht, w_snap_ha, w_snap_vt, w_snap_va};
            {r_prev_ht, r_prev_ha, r_prev_vt, r_prev_va} <= {w_snap_ht, w_snap_ha, w_snap_vt, w_snap_va};
            if (!(w_snap_ok && w_snap_eq)) begin
              r_state   <= S_MEASURE;
              r_match   <= 4'd0;
              locked    <= 1'b0;
              mode      <= 4'd0;
              lock_lost <= 1'b1;
            end
          end
          default: r_state <= S_SEARCH;
        endcase
      end
    end
  end
endmodule
